// File: rtl/ex_mem_pkg.sv
// Shared types and reset constants for the EX/MEM pipeline stage.
package ex_mem_pkg;

    typedef enum logic [1:0] {
        ResAlu = 2'b00,
        ResMem = 2'b01,
        ResPc4 = 2'b10
    } result_src_t;

    typedef enum logic [0:0] {
        StRun    = 1'b0,
        StSquash = 1'b1
    } squash_state_t;

    typedef struct packed {
        logic        valid;
        logic        reg_write;
        logic        mem_write;
        result_src_t result_src;
    } m_ctrl_t;

    localparam m_ctrl_t MCtrlRst = '{
        valid:      1'b0,
        reg_write:  1'b0,
        mem_write:  1'b0,
        result_src: ResAlu
    };

endpackage

// File: rtl/ex_redirect_ctrl.sv
// Branch/jump resolution: squash FSM, registered fetch redirect and optional
// performance counters (enabled by EX_MEM_PERF_CNT_EN).
module ex_redirect_ctrl
    import ex_mem_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  valid_e,
    input  logic                  branch_e,
    input  logic                  jump_e,
    input  logic                  zero,
    input  logic                  stall,
    input  logic [DATA_WIDTH-1:0] pc_target_e,
    output logic                  squash,
    output logic                  pc_src,
    output logic [DATA_WIDTH-1:0] pc_target_m,
    output logic [31:0]           branch_count,
    output logic [31:0]           taken_count
);

    squash_state_t         state_q, state_d;
    logic                  pc_src_q, pc_src_d;
    logic [DATA_WIDTH-1:0] pc_target_q, pc_target_d;
    logic                  take;
    logic                  run_accept;

    assign take       = valid_e & ((branch_e & zero) | jump_e);
    assign run_accept = ~stall & (state_q == StRun);

    always_comb begin
        state_d     = state_q;
        pc_src_d    = 1'b0;   // the redirect is a single-cycle pulse, even under stall
        pc_target_d = pc_target_q;
        if (!stall) begin
            unique case (state_q)
                StRun: begin
                    if (take) begin
                        state_d     = StSquash;
                        pc_src_d    = 1'b1;
                        pc_target_d = pc_target_e;
                    end
                end
                StSquash: state_d = StRun;
                default:  state_d = StRun;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StRun;
            pc_src_q    <= 1'b0;
            pc_target_q <= '0;
        end else begin
            state_q     <= state_d;
            pc_src_q    <= pc_src_d;
            pc_target_q <= pc_target_d;
        end
    end

    assign squash      = (state_q == StSquash);
    assign pc_src      = pc_src_q;
    assign pc_target_m = pc_target_q;

`ifdef EX_MEM_PERF_CNT_EN
    logic [31:0] branch_count_q, taken_count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            branch_count_q <= '0;
            taken_count_q  <= '0;
        end else if (run_accept) begin
            if (valid_e & (branch_e | jump_e)) branch_count_q <= branch_count_q + 32'd1;
            if (take)                          taken_count_q  <= taken_count_q + 32'd1;
        end
    end

    assign branch_count = branch_count_q;
    assign taken_count  = taken_count_q;
`else
    logic unused_run_accept;
    assign unused_run_accept = run_accept;
    assign branch_count      = '0;
    assign taken_count       = '0;
`endif

endmodule

// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline register with branch resolution and wrong-path squash.
// Performance counters are built only when EX_MEM_PERF_CNT_EN is defined.
module ex_mem_stage
    import ex_mem_pkg::*;
#(
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned REG_ADDR_WIDTH = 5
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [DATA_WIDTH-1:0]     ALUResult,
    input  logic                      Zero,
    input  logic [DATA_WIDTH-1:0]     WriteDataE,
    input  logic [DATA_WIDTH-1:0]     PCTargetE,
    input  logic [DATA_WIDTH-1:0]     PCPlus4E,
    input  logic [REG_ADDR_WIDTH-1:0] RdE,
    input  logic                      RegWriteE,
    input  logic                      MemWriteE,
    input  logic                      BranchE,
    input  logic                      JumpE,
    input  logic [1:0]                ResultSrcE,
    input  logic                      ValidE,
    input  logic                      StallM,
    output logic [DATA_WIDTH-1:0]     ALUResultM,
    output logic [DATA_WIDTH-1:0]     WriteDataM,
    output logic [DATA_WIDTH-1:0]     PCPlus4M,
    output logic [REG_ADDR_WIDTH-1:0] RdM,
    output logic                      RegWriteM,
    output logic                      MemWriteM,
    output logic [1:0]                ResultSrcM,
    output logic                      ValidM,
    output logic                      PCSrc,
    output logic [DATA_WIDTH-1:0]     PCTargetM,
    output logic                      FlushD,
    output logic                      FlushE,
    output logic [31:0]               BranchCount,
    output logic [31:0]               TakenCount
);

    logic                      squash;
    logic                      valid_in;
    m_ctrl_t                   ctrl_q, ctrl_d;
    logic [DATA_WIDTH-1:0]     alu_result_q, write_data_q, pc_plus4_q;
    logic [REG_ADDR_WIDTH-1:0] rd_q;

    ex_redirect_ctrl #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_redirect (
        .clk          (clk),
        .rst_n        (rst_n),
        .valid_e      (ValidE),
        .branch_e     (BranchE),
        .jump_e       (JumpE),
        .zero         (Zero),
        .stall        (StallM),
        .pc_target_e  (PCTargetE),
        .squash       (squash),
        .pc_src       (PCSrc),
        .pc_target_m  (PCTargetM),
        .branch_count (BranchCount),
        .taken_count  (TakenCount)
    );

    // The slot behind a taken branch still loads its data but never becomes valid.
    assign valid_in = ValidE & ~squash;

    always_comb begin
        ctrl_d            = MCtrlRst;
        ctrl_d.valid      = valid_in;
        ctrl_d.reg_write  = RegWriteE & valid_in;
        ctrl_d.mem_write  = MemWriteE & valid_in;
        ctrl_d.result_src = result_src_t'(ResultSrcE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl_q       <= MCtrlRst;
            alu_result_q <= '0;
            write_data_q <= '0;
            pc_plus4_q   <= '0;
            rd_q         <= '0;
        end else if (!StallM) begin
            ctrl_q       <= ctrl_d;
            alu_result_q <= ALUResult;
            write_data_q <= WriteDataE;
            pc_plus4_q   <= PCPlus4E;
            rd_q         <= RdE;
        end
    end

    assign ALUResultM = alu_result_q;
    assign WriteDataM = write_data_q;
    assign PCPlus4M   = pc_plus4_q;
    assign RdM        = rd_q;
    assign RegWriteM  = ctrl_q.reg_write;
    assign MemWriteM  = ctrl_q.mem_write;
    assign ResultSrcM = ctrl_q.result_src;
    assign ValidM     = ctrl_q.valid;
    assign FlushD     = PCSrc;
    assign FlushE     = PCSrc;

endmodule

// File: tb/tb_ex_mem_stage.sv
// Self-checking bench for ex_mem_stage: directed scenarios plus randomized
// traffic checked against a slot-level reference model.
module tb_ex_mem_stage;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int VW = 3 * DW + AW + 6 + DW + 2 + 64;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [DW-1:0] alu_result, write_data_e, pc_target_e, pc_plus4_e;
    logic          zero, reg_write_e, mem_write_e, branch_e, jump_e, valid_e, stall_m;
    logic [AW-1:0] rd_e;
    logic [1:0]    result_src_e;

    logic [DW-1:0] alu_result_m, write_data_m, pc_plus4_m, pc_target_m;
    logic [AW-1:0] rd_m;
    logic          reg_write_m, mem_write_m, valid_m, pc_src, flush_d, flush_e;
    logic [1:0]    result_src_m;
    logic [31:0]   branch_count, taken_count;

    // Reference model: what M must hold, plus whether the next EX slot is wrong-path.
    logic [DW-1:0] e_alu, e_wd, e_pc4, e_target;
    logic [AW-1:0] e_rd;
    logic [1:0]    e_rsrc;
    logic          e_valid, e_rw, e_mw, e_pcsrc, pend;
    int unsigned   e_bc, e_tc;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    ex_mem_stage #(
        .DATA_WIDTH     (DW),
        .REG_ADDR_WIDTH (AW)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .ALUResult   (alu_result),
        .Zero        (zero),
        .WriteDataE  (write_data_e),
        .PCTargetE   (pc_target_e),
        .PCPlus4E    (pc_plus4_e),
        .RdE         (rd_e),
        .RegWriteE   (reg_write_e),
        .MemWriteE   (mem_write_e),
        .BranchE     (branch_e),
        .JumpE       (jump_e),
        .ResultSrcE  (result_src_e),
        .ValidE      (valid_e),
        .StallM      (stall_m),
        .ALUResultM  (alu_result_m),
        .WriteDataM  (write_data_m),
        .PCPlus4M    (pc_plus4_m),
        .RdM         (rd_m),
        .RegWriteM   (reg_write_m),
        .MemWriteM   (mem_write_m),
        .ResultSrcM  (result_src_m),
        .ValidM      (valid_m),
        .PCSrc       (pc_src),
        .PCTargetM   (pc_target_m),
        .FlushD      (flush_d),
        .FlushE      (flush_e),
        .BranchCount (branch_count),
        .TakenCount  (taken_count)
    );

    function automatic logic [VW-1:0] dut_vec();
        return {alu_result_m, write_data_m, pc_plus4_m, rd_m, reg_write_m, mem_write_m,
                result_src_m, valid_m, pc_src, pc_target_m, flush_d, flush_e,
                branch_count, taken_count};
    endfunction

    function automatic logic [VW-1:0] exp_vec();
        logic [31:0] bc, tc;
`ifdef EX_MEM_PERF_CNT_EN
        bc = e_bc;
        tc = e_tc;
`else
        bc = 32'd0;
        tc = 32'd0;
`endif
        return {e_alu, e_wd, e_pc4, e_rd, e_rw, e_mw, e_rsrc, e_valid, e_pcsrc, e_target,
                e_pcsrc, e_pcsrc, bc, tc};
    endfunction

    task automatic model_reset();
        e_alu = '0; e_wd = '0; e_pc4 = '0; e_target = '0; e_rd = '0; e_rsrc = '0;
        e_valid = 0; e_rw = 0; e_mw = 0; e_pcsrc = 0; pend = 0; e_bc = 0; e_tc = 0;
    endtask

    task automatic model_edge();
        logic took;
        if (stall_m) begin
            e_pcsrc = 1'b0;
        end else begin
            took    = !pend && valid_e && ((branch_e && zero) || jump_e);
            e_alu   = alu_result;
            e_wd    = write_data_e;
            e_pc4   = pc_plus4_e;
            e_rd    = rd_e;
            e_rsrc  = result_src_e;
            e_valid = valid_e && !pend;
            e_rw    = reg_write_e && e_valid;
            e_mw    = mem_write_e && e_valid;
            if (!pend && valid_e && (branch_e || jump_e)) e_bc = e_bc + 1;
            if (took) begin
                e_tc     = e_tc + 1;
                e_target = pc_target_e;
            end
            e_pcsrc = took;
            pend    = took;
        end
    endtask

    task automatic idle();
        alu_result = '0; write_data_e = '0; pc_target_e = '0; pc_plus4_e = '0; rd_e = '0;
        zero = 0; reg_write_e = 0; mem_write_e = 0; branch_e = 0; jump_e = 0; valid_e = 0;
        result_src_e = '0; stall_m = 0;
    endtask

    task automatic cycle();
        @(posedge clk);
        if (rst_n) model_edge();
        #1;
    endtask

    task automatic async_reset();
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
    endtask

    task automatic test_reset();
        idle();
        valid_e = 1; reg_write_e = 1; alu_result = 32'h0000_1234; rd_e = 5;
        cycle();
        n_vec++;
        if (alu_result_m !== 32'h1234) begin
            n_err++; $display("FAIL reset_alu got %h want %h", alu_result_m, 32'h1234);
        end
        n_vec++;
        if (rd_m !== 5'd5) begin
            n_err++; $display("FAIL reset_rd got %0d want 5", rd_m);
        end
        n_vec++;
        if ({reg_write_m, valid_m} !== 2'b11) begin
            n_err++; $display("FAIL reset_ctrl got %b want 11", {reg_write_m, valid_m});
        end
        async_reset();
        n_vec++;
        if (dut_vec() !== {VW{1'b0}}) begin
            n_err++; $display("FAIL reset_async got %h want 0", dut_vec());
        end
        rst_n = 1'b1;
    endtask

    task automatic test_taken_branch();
        idle();
        valid_e = 1; branch_e = 1; zero = 1; pc_target_e = 32'h100; alu_result = 32'h11;
        cycle();
        n_vec++;
        if ({pc_src, flush_d, flush_e, pc_target_m} !== {3'b111, 32'h100}) begin
            n_err++; $display("FAIL taken_redirect got %b%b%b %h want 111 00000100",
                              pc_src, flush_d, flush_e, pc_target_m);
        end
        idle();
        valid_e = 1; mem_write_e = 1; alu_result = 32'h22;
        cycle();
        n_vec++;
        if ({valid_m, mem_write_m, pc_src} !== 3'b000) begin
            n_err++; $display("FAIL taken_squash got %b want 000", {valid_m, mem_write_m, pc_src});
        end
        n_vec++;
        if (dut_vec() !== exp_vec()) begin
            n_err++; $display("FAIL taken_model got %h want %h", dut_vec(), exp_vec());
        end
    endtask

    task automatic test_not_taken();
        idle();
        valid_e = 1; branch_e = 1; zero = 0; pc_target_e = 32'h200;
        cycle();
        n_vec++;
        if (pc_src !== 1'b0) begin
            n_err++; $display("FAIL nt_pcsrc got %b want 0", pc_src);
        end
        idle();
        valid_e = 1; reg_write_e = 1; rd_e = 7; alu_result = 32'hBEEF; result_src_e = 2'b10;
        cycle();
        n_vec++;
        if ({valid_m, reg_write_m, rd_m, result_src_m} !== {2'b11, 5'd7, 2'b10}) begin
            n_err++; $display("FAIL nt_next got %b%b %0d %b want 11 7 10",
                              valid_m, reg_write_m, rd_m, result_src_m);
        end
    endtask

    task automatic test_stall();
        int pulses = 0;
        idle();
        valid_e = 1; jump_e = 1; pc_target_e = 32'h300; alu_result = 32'hAAAA; rd_e = 1;
        reg_write_e = 1;
        cycle();
        pulses += int'(pc_src);
        idle();
        valid_e = 1; reg_write_e = 1; alu_result = 32'h5555; rd_e = 9; stall_m = 1;
        for (int i = 0; i < 3; i++) begin
            cycle();
            pulses += int'(pc_src);
            n_vec++;
            if ({alu_result_m, rd_m, valid_m, pc_target_m} !== {32'hAAAA, 5'd1, 1'b1, 32'h300})
            begin
                n_err++; $display("FAIL stall_hold[%0d] got %h %0d %b %h", i,
                                  alu_result_m, rd_m, valid_m, pc_target_m);
            end
        end
        n_vec++;
        if (pulses !== 1) begin
            n_err++; $display("FAIL stall_pulses got %0d want 1", pulses);
        end
        stall_m = 0;
        cycle();
        n_vec++;
        if ({valid_m, reg_write_m, alu_result_m} !== {2'b00, 32'h5555}) begin
            n_err++; $display("FAIL stall_squash got %b%b %h want 00 5555",
                              valid_m, reg_write_m, alu_result_m);
        end
        cycle();
        n_vec++;
        if (valid_m !== 1'b1) begin
            n_err++; $display("FAIL stall_resume got %b want 1", valid_m);
        end
    endtask

    task automatic test_reset_mid_squash();
        idle();
        valid_e = 1; jump_e = 1; pc_target_e = 32'h400;
        cycle();
        async_reset();
        n_vec++;
        if ({valid_m, pc_src, pc_target_m} !== {2'b00, 32'h0}) begin
            n_err++; $display("FAIL rstsq_clear got %b%b %h want 00 0", valid_m, pc_src,
                              pc_target_m);
        end
        rst_n = 1'b1;
        idle();
        valid_e = 1; reg_write_e = 1; rd_e = 3;
        cycle();
        n_vec++;
        if ({valid_m, reg_write_m, rd_m} !== {2'b11, 5'd3}) begin
            n_err++; $display("FAIL rstsq_accept got %b%b %0d want 11 3", valid_m, reg_write_m,
                              rd_m);
        end
    endtask

    task automatic test_perf_counters();
        // branch taken?, jump?  ; a filler follows every taken slot
        logic [1:0] seq [5];
        logic [31:0] want_b, want_t;
        seq = '{2'b10, 2'b00, 2'b10, 2'b00, 2'b01};
        cycle();
        async_reset();
        rst_n = 1'b1;
        foreach (seq[i]) begin
            idle();
            valid_e = 1; branch_e = ~seq[i][0]; jump_e = seq[i][0]; zero = seq[i][1];
            pc_target_e = 32'h1000 + i;
            cycle();
            if (seq[i] != 2'b00) begin
                idle();
                valid_e = 1; branch_e = 1; zero = 1;
                cycle();
            end
        end
`ifdef EX_MEM_PERF_CNT_EN
        want_b = 32'd5; want_t = 32'd3;
`else
        want_b = 32'd0; want_t = 32'd0;
`endif
        n_vec++;
        if (branch_count !== want_b) begin
            n_err++; $display("FAIL perf_branch got %0d want %0d", branch_count, want_b);
        end
        n_vec++;
        if (taken_count !== want_t) begin
            n_err++; $display("FAIL perf_taken got %0d want %0d", taken_count, want_t);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            alu_result   = $urandom;
            write_data_e = $urandom;
            pc_target_e  = $urandom;
            pc_plus4_e   = $urandom;
            rd_e         = AW'($urandom);
            result_src_e = 2'($urandom_range(0, 2));
            zero         = 1'($urandom);
            reg_write_e  = 1'($urandom);
            mem_write_e  = 1'($urandom);
            branch_e     = ($urandom_range(0, 3) == 0);
            jump_e       = ($urandom_range(0, 7) == 0);
            valid_e      = ($urandom_range(0, 4) != 0);
            stall_m      = ($urandom_range(0, 3) == 0);
            cycle();
            n_vec++;
            if (dut_vec() !== exp_vec()) begin
                n_err++; $display("FAIL random[%0d] got %h want %h", i, dut_vec(), exp_vec());
            end
        end
    endtask

    initial begin
        idle();
        model_reset();
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        test_reset();
        test_taken_branch();
        test_not_taken();
        test_stall();
        test_reset_mid_squash();
        test_perf_counters();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
